// File: rtl/du_share_ctrl_pkg.sv
// rtl/du_share_ctrl_pkg.sv - constants, types and Mitchell log2 helper for the shared DU controller
package du_share_ctrl_pkg;
  localparam int Q = 16;
  localparam int W = 64;

  typedef logic signed [W-1:0] q48_16_t;

  typedef struct packed {
    q48_16_t exp;
    logic    sign;
    logic    zero;
  } du_rsp_t;

  // log2(x) ~= msb + (x / 2^msb - 1); x is an unsigned Q48.16 magnitude, result is signed Q48.16
  function automatic q48_16_t mitchell_log2(input logic [W-1:0] x);
    int           p;
    logic [Q-1:0] frac;
    p = 0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) p = i;
    end
    frac = Q'((x << (W - 1 - p)) >> (W - 1 - Q));
    return (q48_16_t'(p - Q) <<< Q) + $signed({{(W-Q){1'b0}}, frac});
  endfunction
endpackage

// File: rtl/du_share_ctrl_du.sv
// rtl/du_share_ctrl_du.sv - combinational log-domain divider: log2|F/(1+s_xi)| and result sign
module du_share_ctrl_du
  import du_share_ctrl_pkg::*;
(
  input  q48_16_t f_i,
  input  q48_16_t sxi_i,
  output q48_16_t exp_o,
  output logic    sign_o
);
  q48_16_t      den;
  logic [W-1:0] f_mag;
  logic [W-1:0] den_mag;

  always_comb begin
    den     = sxi_i + (q48_16_t'(1) <<< Q);
    f_mag   = f_i[W-1] ? -f_i : f_i;
    den_mag = den[W-1] ? -den : den;
    sign_o  = f_i[W-1] ^ den[W-1];
    exp_o   = mitchell_log2(f_mag) - mitchell_log2(den_mag);
  end
endmodule

// File: rtl/du_share_ctrl_rr_arbiter.sv
// rtl/du_share_ctrl_rr_arbiter.sv - round-robin arbiter, pointer moves past the winner on advance
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o
);
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  always_comb begin
    int k;
    k           = 0;
    grant_o     = '0;
    grant_idx_o = ptr_q;
    // walk from farthest to nearest so the closest request at/after the pointer wins
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (req_i[k]) grant_idx_o = ID_W'(k);
    end
    if (req_i != '0) grant_o[grant_idx_o] = 1'b1;
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (int'(grant_idx_o) == N_REQ - 1) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/du_share_ctrl.sv
// rtl/du_share_ctrl.sv - shares one DU between N_REQ lanes with a two-stage valid/ready pipeline
module du_share_ctrl
  import du_share_ctrl_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_f,
  input  logic [N_REQ*W-1:0] req_sxi,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_exponent,
  output logic               rsp_sign,
  output logic               rsp_zero,
  output logic [ID_W-1:0]    rsp_id,
  output logic               idle
);
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             b_adv;
  logic             a_free;
  logic             accept;
  logic             a_vld_q, a_vld_d;
  logic             b_vld_q, b_vld_d;
  q48_16_t          a_f_q, a_sxi_q;
  logic [ID_W-1:0]  a_id_q, b_id_q;
  du_rsp_t          b_rsp_q, du_rsp;
  q48_16_t          du_exp;
  logic             du_sign;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_valid),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  du_share_ctrl_du u_du (
    .f_i    (a_f_q),
    .sxi_i  (a_sxi_q),
    .exp_o  (du_exp),
    .sign_o (du_sign)
  );

  always_comb begin
    b_adv     = a_vld_q & (~b_vld_q | rsp_ready);
    a_free    = ~a_vld_q | b_adv;
    req_ready = (a_free & rst_n) ? grant : '0;
    accept    = |(req_valid & req_ready);
    a_vld_d   = accept | (a_vld_q & ~b_adv);
    b_vld_d   = b_adv | (b_vld_q & ~rsp_ready);
    // a zero numerator has no logarithm; report it as a flag with a clean payload
    du_rsp.zero = (a_f_q == '0);
    du_rsp.exp  = du_rsp.zero ? '0 : du_exp;
    du_rsp.sign = du_rsp.zero ? 1'b0 : du_sign;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_vld_q <= 1'b0;
      a_f_q   <= '0;
      a_sxi_q <= '0;
      a_id_q  <= '0;
      b_vld_q <= 1'b0;
      b_rsp_q <= '0;
      b_id_q  <= '0;
    end else begin
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      if (accept) begin
        a_f_q   <= req_f[grant_idx*W +: W];
        a_sxi_q <= req_sxi[grant_idx*W +: W];
        a_id_q  <= grant_idx;
      end
      if (b_adv) begin
        b_rsp_q <= du_rsp;
        b_id_q  <= a_id_q;
      end
    end
  end

  assign rsp_valid    = b_vld_q;
  assign rsp_exponent = b_rsp_q.exp;
  assign rsp_sign     = b_rsp_q.sign;
  assign rsp_zero     = b_rsp_q.zero;
  assign rsp_id       = b_id_q;
  assign idle         = ~a_vld_q & ~b_vld_q;
endmodule

// File: tb/tb_du_share_ctrl.sv
// tb/tb_du_share_ctrl.sv - directed and random self-checking bench for du_share_ctrl
module tb_du_share_ctrl;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [127:0] req_f = '0;
  logic [127:0] req_sxi = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [63:0]  rsp_exponent;
  logic         rsp_sign;
  logic         rsp_zero;
  logic [0:0]   rsp_id;
  logic         idle;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  typedef struct {
    int                 id;
    logic signed [63:0] f;
    logic signed [63:0] sxi;
  } op_t;
  op_t sb[$];

  du_share_ctrl #(.N_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_f        (req_f),
    .req_sxi      (req_sxi),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_exponent (rsp_exponent),
    .rsp_sign     (rsp_sign),
    .rsp_zero     (rsp_zero),
    .rsp_id       (rsp_id),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic check_rsp();
    op_t                e;
    logic signed [63:0] den;
    real                t;
    real                r;
    logic               ok;
    if (sb.size() == 0) begin
      chk("rsp_unexpected", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk("rsp_id", 64'(rsp_id), 64'(e.id));
    chk("rsp_zero", 64'(rsp_zero), 64'(e.f == 0));
    if (e.f == 0) begin
      chk("rsp_zero_exp", rsp_exponent, 64'd0);
    end else begin
      den = e.sxi + 64'sh10000;
      chk("rsp_sign", 64'(rsp_sign), 64'(e.f[63] ^ den[63]));
      t = real'(e.f) / real'(den);
      if (t < 0.0) t = -t;
      r = 2.0 ** (real'($signed(rsp_exponent)) / 65536.0);
      ok = (r > t * 0.75) && (r < t * 1.25);
      chk("rsp_mag", 64'(ok), 64'd1);
    end
  endtask

  // inputs are set at the negedge; observe #1 later, then move to the next negedge
  task automatic tick();
    #1;
    if (rst_n) begin
      if (rsp_valid && rsp_ready) check_rsp();
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          sb.push_back('{k, req_f[k*64 +: 64], req_sxi[k*64 +: 64]});
          n_acc++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input int k, input logic [63:0] f, input logic [63:0] sxi);
    req_f[k*64 +: 64]   = f;
    req_sxi[k*64 +: 64] = sxi;
  endtask

  task automatic single_op(input string tag, input logic [63:0] f, input logic [63:0] sxi,
                           input logic [63:0] exp_e, input logic sign_e, input logic zero_e);
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    set_op(0, f, sxi);
    #1 chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    chk({tag, "_early"}, 64'(rsp_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_exp"}, rsp_exponent, exp_e);
    chk({tag, "_sign"}, 64'(rsp_sign), 64'(sign_e));
    chk({tag, "_zero"}, 64'(rsp_zero), 64'(zero_e));
    chk({tag, "_id"}, 64'(rsp_id), 64'd0);
    tick();
  endtask

  function automatic logic [63:0] rand_f();
    logic [63:0] mag;
    mag = 64'($urandom_range(0, 32'h00FF_FFFF));
    if ($urandom_range(0, 7) == 0) mag = '0;
    return ($urandom_range(0, 1) != 0) ? -mag : mag;
  endfunction

  initial begin
    int acc0;
    int cyc;
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1 chk("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_exp", rsp_exponent, 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_flags", 64'({rsp_sign, rsp_zero}), 64'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    @(negedge clk);

    // 7/3: log2 7 ~ 2.75, log2 3 ~ 1.5 -> 1.25 ; -17/4: 4.0625 - 2 -> 2.0625
    single_op("op_7_3", 64'h70000, 64'h20000, 64'h14000, 1'b0, 1'b0);
    single_op("op_m17_4", -64'h110000, 64'h30000, 64'h21000, 1'b1, 1'b0);
    single_op("op_zero", 64'h0, 64'h20000, 64'h0, 1'b0, 1'b1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 2'b11;
    set_op(0, 64'h70000, 64'h20000);
    set_op(1, -64'h110000, 64'h30000);
    for (int c = 0; c < 8; c++) begin
      #1 chk("fair_grant", 64'(req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
      if (c >= 2) chk("fair_rsp", 64'(rsp_valid), 64'd1);
      tick();
    end
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    chk("fair_idle", 64'(idle), 64'd1);

    rsp_ready = 1'b0;
    req_valid = 2'b01;
    set_op(0, 64'h70000, 64'h20000);
    acc0 = n_acc;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) set_op(0, -64'h110000, 64'h30000);
      #1;
      if (c >= 2) begin
        chk("bp_ready", 64'(req_ready), 64'd0);
        chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
        chk("bp_hold_exp", rsp_exponent, 64'h14000);
      end
      tick();
    end
    chk("bp_accepts", 64'(n_acc - acc0), 64'd2);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_drained", 64'(sb.size()), 64'd0);
    chk("bp_idle", 64'(idle), 64'd1);

    rsp_ready = 1'b0;
    req_valid = 2'b01;
    tick();
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_idle", 64'(idle), 64'd1);
    req_valid = 2'b11;
    #1 chk("midrst_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("midrst_drained", 64'(sb.size()), 64'd0);

    acc0 = n_acc;
    cyc  = 0;
    while ((n_acc - acc0) < 400 && cyc < 20000) begin
      for (int k = 0; k < N; k++) begin
        req_valid[k] = ($urandom_range(0, 3) != 0);
        set_op(k, rand_f(), 64'($urandom_range(0, 32'h80000)) - 64'h8000);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("rand_count", 64'((n_acc - acc0) >= 400), 64'd1);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_idle", 64'(idle), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
